// File: rtl/pasc_top.sv
// pasc_top: multicore PASC top level.
//   pasc_top -> cluster (pasc_cluster) -> core0..core7 (pasc_core) -> local_memory (pasc_mem, array `data`)
//   pasc_top -> arbiter (pasc_arbiter) drives the shared output device.
// Build option: define PASC_FIXED_PRIORITY_EN for fixed lowest-index-wins
// arbitration; the default build is round-robin.
// The cluster hierarchy is fixed at eight named cores (NUM_CORES 1..8); cores at
// or above NUM_CORES are held in reset permanently and never reach the arbiter.

// Local single-port-write, dual-read-port word memory. Contents survive reset.
module pasc_mem #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic [AW-1:0] iaddr,
  output logic [15:0]   idata,
  input  logic [AW-1:0] daddr,
  output logic [15:0]   rdata,
  input  logic          we,
  input  logic [15:0]   wdata
);
  logic [15:0] data [DEPTH];

  assign idata = data[iaddr];
  assign rdata = data[daddr];

  // Store port; deliberately not reset so preloaded images persist.
  always_ff @(posedge clk) begin
    if (we) begin
      data[daddr] <= wdata;
    end
  end
endmodule

// Single-cycle 16-bit core: fetch, decode and execute in one cycle from local
// memory. OUT stalls in place until the arbiter acks, so a run of OUT
// instructions can present one word per cycle.
//   insn = op[15:12] rd[11:8] rs[7:4] / imm[7:0]
module pasc_core #(
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] core_id,
  output logic            out_req,
  output logic [15:0]     out_data,
  input  logic            out_ack
);
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,  // no operation
    OP_LDI  = 4'h1,  // rd = {8'h00, imm}
    OP_LUI  = 4'h2,  // rd = {imm, rd[7:0]}
    OP_CID  = 4'h3,  // rd = core_id
    OP_ADD  = 4'h4,  // rd = rd + rs
    OP_OUT  = 4'h5,  // device write of rd, held until acked
    OP_LD   = 4'h6,  // rd = mem[rs]
    OP_ST   = 4'h7,  // mem[rs] = rd
    OP_BNZ  = 4'h8,  // if (rd != 0) pc = imm
    OP_ADDI = 4'h9,  // rd = rd + sext(imm)
    OP_HALT = 4'hF   // stop fetching
  } op_t;

  state_t        state, state_next;
  logic [AW-1:0] pc, pc_next;
  logic [15:0]   regs [16];
  logic [15:0]   instr, mem_rdata, rd_val, rs_val, reg_wdata;
  logic          reg_we, mem_we;
  op_t           op;
  logic [3:0]    rd, rs;
  logic [7:0]    imm;

  assign op       = op_t'(instr[15:12]);
  assign rd       = instr[11:8];
  assign rs       = instr[7:4];
  assign imm      = instr[7:0];
  assign rd_val   = regs[rd];
  assign rs_val   = regs[rs];
  assign out_data = rd_val;

  // Stores are suppressed while reset is held so memory images stay intact.
  pasc_mem #(.AW(AW), .DEPTH(DEPTH)) local_memory (
    .clk   (clk),
    .iaddr (pc),
    .idata (instr),
    .daddr (rs_val[AW-1:0]),
    .rdata (mem_rdata),
    .we    (mem_we & rst_n),
    .wdata (rd_val)
  );

  // Run/halt state and program counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Register file write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[rd] <= reg_wdata;
    end
  end

  // Decode/execute: next state, next pc, write-back and device request.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    reg_we     = 1'b0;
    reg_wdata  = '0;
    mem_we     = 1'b0;
    out_req    = 1'b0;
    if (state == S_RUN) begin
      pc_next = pc + 1'b1;
      unique case (op)
        OP_LDI: begin
          reg_we    = 1'b1;
          reg_wdata = {8'h00, imm};
        end
        OP_LUI: begin
          reg_we    = 1'b1;
          reg_wdata = {imm, rd_val[7:0]};
        end
        OP_CID: begin
          reg_we    = 1'b1;
          reg_wdata = 16'(core_id);
        end
        OP_ADD: begin
          reg_we    = 1'b1;
          reg_wdata = rd_val + rs_val;
        end
        OP_ADDI: begin
          reg_we    = 1'b1;
          reg_wdata = rd_val + {{8{imm[7]}}, imm};
        end
        OP_LD: begin
          reg_we    = 1'b1;
          reg_wdata = mem_rdata;
        end
        OP_ST: begin
          mem_we = 1'b1;
        end
        OP_OUT: begin
          out_req = 1'b1;
          if (!out_ack) begin
            pc_next = pc;
          end
        end
        OP_BNZ: begin
          if (rd_val != '0) begin
            pc_next = imm;
          end
        end
        OP_HALT: begin
          state_next = S_HALT;
          pc_next    = pc;
        end
        default: begin
          // OP_NOP and unassigned opcodes just advance.
        end
      endcase
    end
  end
endmodule

// Cluster of eight fixed-name cores; each gets its index as core_id.
module pasc_cluster #(
  parameter int NUM_CORES = 8,
  parameter int ID_W      = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [NUM_CORES-1:0]       out_req,
  output logic [NUM_CORES-1:0][15:0] out_data,
  input  logic [NUM_CORES-1:0]       out_ack
);
  localparam int MAX_CORES = 8;

  logic [MAX_CORES-1:0]       req_all, ack_all, rst_all;
  logic [MAX_CORES-1:0][15:0] data_all;

  // Only the first NUM_CORES cores are live; the rest stay in reset.
  for (genvar k = 0; k < MAX_CORES; k++) begin : g_map
    if (k < NUM_CORES) begin : g_used
      assign rst_all[k]  = rst_n;
      assign ack_all[k]  = out_ack[k];
      assign out_req[k]  = req_all[k];
      assign out_data[k] = data_all[k];
    end else begin : g_unused
      assign rst_all[k] = 1'b0;
      assign ack_all[k] = 1'b0;
    end
  end

  pasc_core #(.ID_W(ID_W)) core0 (
    .clk(clk), .rst_n(rst_all[0]), .core_id(ID_W'(0)),
    .out_req(req_all[0]), .out_data(data_all[0]), .out_ack(ack_all[0])
  );
  pasc_core #(.ID_W(ID_W)) core1 (
    .clk(clk), .rst_n(rst_all[1]), .core_id(ID_W'(1)),
    .out_req(req_all[1]), .out_data(data_all[1]), .out_ack(ack_all[1])
  );
  pasc_core #(.ID_W(ID_W)) core2 (
    .clk(clk), .rst_n(rst_all[2]), .core_id(ID_W'(2)),
    .out_req(req_all[2]), .out_data(data_all[2]), .out_ack(ack_all[2])
  );
  pasc_core #(.ID_W(ID_W)) core3 (
    .clk(clk), .rst_n(rst_all[3]), .core_id(ID_W'(3)),
    .out_req(req_all[3]), .out_data(data_all[3]), .out_ack(ack_all[3])
  );
  pasc_core #(.ID_W(ID_W)) core4 (
    .clk(clk), .rst_n(rst_all[4]), .core_id(ID_W'(4)),
    .out_req(req_all[4]), .out_data(data_all[4]), .out_ack(ack_all[4])
  );
  pasc_core #(.ID_W(ID_W)) core5 (
    .clk(clk), .rst_n(rst_all[5]), .core_id(ID_W'(5)),
    .out_req(req_all[5]), .out_data(data_all[5]), .out_ack(ack_all[5])
  );
  pasc_core #(.ID_W(ID_W)) core6 (
    .clk(clk), .rst_n(rst_all[6]), .core_id(ID_W'(6)),
    .out_req(req_all[6]), .out_data(data_all[6]), .out_ack(ack_all[6])
  );
  pasc_core #(.ID_W(ID_W)) core7 (
    .clk(clk), .rst_n(rst_all[7]), .core_id(ID_W'(7)),
    .out_req(req_all[7]), .out_data(data_all[7]), .out_ack(ack_all[7])
  );
endmodule

// Output device arbiter: combinational grant, registered device outputs.
module pasc_arbiter #(
  parameter int NUM_CORES = 8,
  parameter int ID_W      = 3,
  parameter int DW        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CORES-1:0]       req,
  input  logic [NUM_CORES-1:0][DW-1:0] data,
  output logic [NUM_CORES-1:0]       ack,
  output logic [DW-1:0]              out_val,
  output logic                       out_en
);
  logic [ID_W-1:0] last_grant, grant_idx;
  logic            grant_valid;
  int unsigned     cand;

  // Pick the first requester in search order.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
`ifdef PASC_FIXED_PRIORITY_EN
      cand = k;
`else
      cand = (32'(last_grant) + 1 + k) % NUM_CORES;
`endif
      if (!grant_valid && req[ID_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // One-hot ack to the winner; never asserted while reset is held.
  always_comb begin
    ack = '0;
    if (grant_valid && rst_n) begin
      ack[grant_idx] = 1'b1;
    end
  end

  // Register the accepted word and remember the winner for rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_CORES - 1);
      out_val    <= '0;
      out_en     <= 1'b0;
    end else if (grant_valid) begin
      last_grant <= grant_idx;
      out_val    <= data[grant_idx];
      out_en     <= 1'b1;
    end else begin
      out_en <= 1'b0;
    end
  end
endmodule

// Top: cluster plus shared output device arbiter.
module pasc_top #(
  parameter int NUM_CORES  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] output_val,
  output logic                  output_enable
);
  localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]                 core_req, core_ack;
  logic [NUM_CORES-1:0][15:0]           core_data;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] dev_data;

  pasc_cluster #(.NUM_CORES(NUM_CORES), .ID_W(ID_W)) cluster (
    .clk      (clk),
    .rst_n    (reset),
    .out_req  (core_req),
    .out_data (core_data),
    .out_ack  (core_ack)
  );

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_dev
    assign dev_data[k] = DATA_WIDTH'(core_data[k]);
  end

  pasc_arbiter #(.NUM_CORES(NUM_CORES), .ID_W(ID_W), .DW(DATA_WIDTH)) arbiter (
    .clk     (clk),
    .rst_n   (reset),
    .req     (core_req),
    .data    (dev_data),
    .ack     (core_ack),
    .out_val (output_val),
    .out_en  (output_enable)
  );
endmodule

// File: tb/tb_pasc_top.sv
// Testbench for pasc_top: preloads every core's local memory with a small
// program, queues the expected device words, and compares each output pulse.
module tb_pasc_top;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] output_val;
  logic        output_enable;
  bit          clk_run = 1'b0;

  pasc_top dut (
    .clk           (clk),
    .reset         (reset),
    .output_val    (output_val),
    .output_enable (output_enable)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_head;
  logic [15:0] img [16];
  int          cyc = 0;
  int          pulses = 0;
  int          prev_cyc = 0;
  int          first_cyc = 0;
  int          req_cyc = -100;
  bit          mon_on = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each pulse must match the queue head on consecutive cycles;
  // with nothing expected, output_enable must stay low.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() == 0) begin
        check("no_extra_pulse", output_enable, 0);
      end else if (output_enable) begin
        exp_head = exp_q.pop_front();
        check("pulse_val", output_val, exp_head);
        if (pulses == 0) first_cyc = cyc;
        else check("pulse_gap", cyc - prev_cyc, 1);
        prev_cyc = cyc;
        pulses++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d pulses", pulses);
    $fatal(1, "simulation time limit");
  end

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = 16'h0000;
  endtask

  task automatic load_img();
    for (int a = 0; a < 16; a++) begin
      dut.cluster.core0.local_memory.data[a] = img[a];
      dut.cluster.core1.local_memory.data[a] = img[a];
      dut.cluster.core2.local_memory.data[a] = img[a];
      dut.cluster.core3.local_memory.data[a] = img[a];
      dut.cluster.core4.local_memory.data[a] = img[a];
      dut.cluster.core5.local_memory.data[a] = img[a];
      dut.cluster.core6.local_memory.data[a] = img[a];
      dut.cluster.core7.local_memory.data[a] = img[a];
    end
  endtask

  // Each core: CID r1; OUT r1 x4; HALT
  task automatic set_contention_img();
    clear_img();
    img[0] = 16'h3100;
    for (int i = 1; i <= 4; i++) img[i] = 16'h5100;
    img[5] = 16'hF000;
  endtask

  task automatic push_contention();
`ifdef PASC_FIXED_PRIORITY_EN
    for (int k = 0; k < 8; k++)
      for (int r = 0; r < 4; r++) exp_q.push_back(16'(k));
`else
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 8; k++) exp_q.push_back(16'(k));
`endif
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (pulses >= n) break;
      @(negedge clk);
      #1;
    end
    check(tag, pulses, n);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic release_reset();
    pulses = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset with the clock idle.
    #1 reset = 1'b0;
    #5;
    check("rst_oe", output_enable, 0);
    check("rst_val", output_val, 0);
    check("rst_ack", dut.core_ack, 0);
    check("rst_last_grant", dut.arbiter.last_grant, 7);

    // Core ID fan-out: LDI r1,00; LUI r1,10; CID r2; ADD r1,r2; OUT r1; HALT
    clear_img();
    img[0] = 16'h1100; img[1] = 16'h2110; img[2] = 16'h3200;
    img[3] = 16'h4120; img[4] = 16'h5100; img[5] = 16'hF000;
    load_img();
    for (int k = 0; k < 8; k++) exp_q.push_back(16'h1000 + 16'(k));
    mon_on  = 1'b1;
    clk_run = 1'b1;
    release_reset();
    wait_pulses(8, 100, "fanout_count");
    repeat (16) @(negedge clk);
    #1 check("fanout_total", pulses, 8);

    // Sustained contention.
    enter_reset();
    set_contention_img();
    load_img();
    push_contention();
    release_reset();
    wait_pulses(32, 200, "contend_count");
    repeat (16) @(negedge clk);
    #1 check("contend_total", pulses, 32);

    // Single requester: only core5 reaches OUT BEEF, OUT 0042.
    enter_reset();
    clear_img();
    img[0] = 16'h3100; img[1] = 16'h91FB; img[2] = 16'h8108;
    img[3] = 16'h13EF; img[4] = 16'h23BE; img[5] = 16'h1442;
    img[6] = 16'h5300; img[7] = 16'h5400; img[8] = 16'hF000;
    load_img();
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h0042);
    release_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (dut.cluster.core5.out_req) begin
        req_cyc = cyc;
        break;
      end
    end
    wait_pulses(2, 50, "single_count");
    check("single_latency", first_cyc - req_cyc, 1);
    repeat (8) @(negedge clk);

    // Reset mid-run after 10 contention pulses.
    enter_reset();
    set_contention_img();
    load_img();
    push_contention();
    release_reset();
    wait_pulses(10, 100, "midrst_pre_count");
    reset = 1'b0;
    #1;
    check("midrst_oe", output_enable, 0);
    check("midrst_val", output_val, 0);
    check("midrst_ack", dut.core_ack, 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    push_contention();
    pulses = 0;
    reset = 1'b1;
    wait_pulses(32, 200, "midrst_post_count");
    repeat (16) @(negedge clk);
    #1 check("midrst_total", pulses, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
